mem_access_unit: RTL and testbench
==================================

# mem_access_unit

Memory-stage consumer of the decoded control word: takes `mem_read`/`mem_write`/`funct3` plus the ALU-computed address and rs2 data, and drives the data-cache request interface with aligned address, byte mask and lane-replicated write data. It holds the request until the cache responds and stalls the pipeline meanwhile. Load data is extracted and sign/zero-extended for the regfile mux. It sits between the EX/MEM pipeline register and the data cache.

## Interface
- No parameters (data width fixed at 32).
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `valid_i`  in  1  EX/MEM contents valid this cycle
- `mem_read_i`  in  1  ctrl.mem_read
- `mem_write_i`  in  1  ctrl.mem_write
- `funct3_i`  in  3  ctrl.funct3 (load/store width)
- `addr_i`  in  32  effective address (ALU out)
- `rs2_i`  in  32  store data
- `stall_o`  out  1  hold upstream stages
- `done_o`  out  1  one-cycle pulse: access complete
- `rdata_o`  out  32  extended load result
- `dmem_read` / `dmem_write`  out  1  cache request strobes
- `dmem_address`  out  32  `{addr[31:2], 2'b00}`
- `dmem_wdata`  out  32  lane-replicated store data
- `dmem_mbe`  out  4  byte enable
- `dmem_rdata`  in  32  cache read data
- `dmem_resp`  in  1  cache response
- `misaligned_o`  out  1  only with `MEM_MISALIGN_TRAP_EN`

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: if `valid_i && (mem_read_i || mem_write_i)`, register funct3, addr, rs2, read/write; go to ACCESS. Read and write both set: treated as read. Non-memory or invalid input: stay IDLE, no stall.
- ACCESS: drive `dmem_read` or `dmem_write` from registered state, hold all request signals stable until `dmem_resp`; on resp, go to DONE (loads capture extended data into `rdata_o`).
- DONE: `done_o=1`, return to IDLE. A new op is accepted in the following IDLE cycle.
- `stall_o` = (IDLE && valid mem op) || ACCESS. Deasserted in DONE.
- Masks: sb `4'b0001 << addr[1:0]`; sh `4'b0011 << {addr[1],1'b0}`; sw/other `4'b1111`. Loads drive `dmem_mbe=4'b1111`.
- wdata: sb `{4{rs2[7:0]}}`, sh `{2{rs2[15:0]}}`, sw `rs2`.
- Load extraction: lb/lbu byte at `addr[1:0]`, lh/lhu half at `addr[1]`, sign/zero extended; lw and undefined funct3 (3,6,7) return full word.
- `rdata_o` holds until the next load completes; stores never change it.
- `dmem_resp` outside ACCESS is ignored.

## Timing
- Reset: state IDLE; `stall_o`, `done_o`, `dmem_read`, `dmem_write`, `misaligned_o` = 0; `dmem_address`, `dmem_wdata`, `rdata_o` = 0; `dmem_mbe` = 0.
- Request first driven the cycle after acceptance; resp in ACCESS cycle k → `done_o` in cycle k+1. Minimum latency accept→done: 2 cycles (resp on first ACCESS cycle).
- Reset in any state: next cycle IDLE, request strobes low, no `done_o` pulse for the aborted op.

## Configuration
- `MEM_MISALIGN_TRAP_EN` defined: lh/lhu/sh with `addr[0]=1`, or lw/sw with `addr[1:0]!=0`, go IDLE→DONE with no cache request; `done_o=1`, `misaligned_o=1` in that cycle, `rdata_o` unchanged.
- Undefined: port `misaligned_o` absent; misaligned accesses issued with low address bits truncated per mask rules above.

## Structure
- `mem_state_t` enum (IDLE/ACCESS/DONE) goes in `rv32i_types`; reuse existing `load_funct3_t`/`store_funct3_t`.
- One combinational sub-module `load_extend` (funct3, addr[1:0], word → 32-bit result).

## Test plan
- sb, addr 0x1003, rs2 0x000000AB, resp after 3 cycles → `dmem_mbe=4'b1000`, wdata 0xABABABAB, address 0x1000, stall 4 cycles, single `done_o`.
- lb addr 0x2001, rdata 0x0000_80FF → `rdata_o=0xFFFFFF80`; lbu same → 0x00000080.
- lh addr 0x2002, rdata 0x8001_0000 → 0xFFFF8001; lhu → 0x00008001.
- Non-memory `valid_i` with ALU op → no request, `stall_o=0`, `rdata_o` unchanged.
- `rst` asserted in ACCESS → strobes low next cycle, no `done_o`; subsequent lw completes normally.
- With `MEM_MISALIGN_TRAP_EN`: lw addr 0x3002 → no `dmem_read`, `done_o` and `misaligned_o` high in the same cycle, one cycle after accept.

Source files
------------

// File: rtl/mem_access_unit_pkg.sv
// Shared RV32I types for the memory stage: load/store widths and
// the memory access FSM encoding.
package rv32i_types;

    typedef enum logic [2:0] {
        lb  = 3'b000,
        lh  = 3'b001,
        lw  = 3'b010,
        lbu = 3'b100,
        lhu = 3'b101
    } load_funct3_t;

    typedef enum logic [2:0] {
        sb = 3'b000,
        sh = 3'b001,
        sw = 3'b010
    } store_funct3_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } mem_state_t;

endpackage

// File: rtl/mem_access_unit_load_extend.sv
// Load data extraction: picks the byte/half lane out of the cache word
// and sign- or zero-extends it to 32 bits.
module load_extend
    import rv32i_types::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  offset,
    input  logic [31:0] word,
    output logic [31:0] result
);

    logic [7:0]  b;
    logic [15:0] h;

    always_comb begin
        unique case (offset)
            2'd0: b = word[7:0];
            2'd1: b = word[15:8];
            2'd2: b = word[23:16];
            default: b = word[31:24];
        endcase
        h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            lb:  result = {{24{b[7]}}, b};
            lbu: result = {24'h0, b};
            lh:  result = {{16{h[15]}}, h};
            lhu: result = {16'h0, h};
            default: result = word;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// Memory stage: issues one data-cache request per load/store and stalls
// until the response. `MEM_MISALIGN_TRAP_EN enables misaligned trapping.
module mem_access_unit
    import rv32i_types::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] rs2_i,
    output logic        stall_o,
    output logic        done_o,
    output logic [31:0] rdata_o,
    output logic        dmem_read,
    output logic        dmem_write,
    output logic [31:0] dmem_address,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_mbe,
    input  logic [31:0] dmem_rdata,
    input  logic        dmem_resp
`ifdef MEM_MISALIGN_TRAP_EN
    ,
    output logic        misaligned_o
`endif
);

    mem_state_t  state;
    logic        rd_q;
    logic [2:0]  f3_q;
    logic [31:0] addr_q;
    logic [31:0] rs2_q;
    logic [31:0] rdata_q;
    logic [31:0] ext;
    logic        req;
    logic        acc;
    logic        mis;

    assign req = valid_i && (mem_read_i || mem_write_i);
    assign acc = (state == ACCESS);

`ifdef MEM_MISALIGN_TRAP_EN
    logic mis_q;

    always_comb begin
        mis = 1'b0;
        if (mem_read_i) begin
            if (funct3_i == lh || funct3_i == lhu)
                mis = addr_i[0];
            else if (funct3_i == lw)
                mis = |addr_i[1:0];
        end else begin
            if (funct3_i == sh)
                mis = addr_i[0];
            else if (funct3_i == sw)
                mis = |addr_i[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst)
            mis_q <= 1'b0;
        else if (state == IDLE && req)
            mis_q <= mis;
        else if (state == DONE)
            mis_q <= 1'b0;
    end

    assign misaligned_o = (state == DONE) && mis_q;
`else
    assign mis = 1'b0;
`endif

    load_extend u_ext (
        .funct3 (f3_q),
        .offset (addr_q[1:0]),
        .word   (dmem_rdata),
        .result (ext)
    );

    // Read+write together is treated as a read: only rd_q is kept.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            rd_q    <= 1'b0;
            f3_q    <= 3'b0;
            addr_q  <= 32'h0;
            rs2_q   <= 32'h0;
            rdata_q <= 32'h0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (req) begin
                        rd_q   <= mem_read_i;
                        f3_q   <= funct3_i;
                        addr_q <= addr_i;
                        rs2_q  <= rs2_i;
                        state  <= mis ? DONE : ACCESS;
                    end
                end
                ACCESS: begin
                    if (dmem_resp) begin
                        state <= DONE;
                        if (rd_q)
                            rdata_q <= ext;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    always_comb begin
        dmem_mbe   = 4'b0000;
        dmem_wdata = 32'h0;
        if (acc) begin
            if (rd_q) begin
                dmem_mbe = 4'b1111;
            end else begin
                case (f3_q)
                    sb: begin
                        dmem_mbe   = 4'b0001 << addr_q[1:0];
                        dmem_wdata = {4{rs2_q[7:0]}};
                    end
                    sh: begin
                        dmem_mbe   = 4'b0011 << {addr_q[1], 1'b0};
                        dmem_wdata = {2{rs2_q[15:0]}};
                    end
                    default: begin
                        dmem_mbe   = 4'b1111;
                        dmem_wdata = rs2_q;
                    end
                endcase
            end
        end
    end

    assign dmem_read    = acc && rd_q;
    assign dmem_write   = acc && !rd_q;
    assign dmem_address = acc ? {addr_q[31:2], 2'b00} : 32'h0;
    assign stall_o      = (state == IDLE && req) || acc;
    assign done_o       = (state == DONE);
    assign rdata_o      = rdata_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level reference
// model with a per-cycle compare, plus pinned literal expectations.
module tb_mem_access_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, rs2_i;
    logic        stall_o, done_o;
    logic [31:0] rdata_o;
    logic        dmem_read, dmem_write;
    logic [31:0] dmem_address, dmem_wdata;
    logic [3:0]  dmem_mbe;
    logic [31:0] dmem_rdata;
    logic        dmem_resp;
    logic        misaligned_o;

    always #5 clk = ~clk;

    mem_access_unit dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .mem_read_i   (mem_read_i),
        .mem_write_i  (mem_write_i),
        .funct3_i     (funct3_i),
        .addr_i       (addr_i),
        .rs2_i        (rs2_i),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .rdata_o      (rdata_o),
        .dmem_read    (dmem_read),
        .dmem_write   (dmem_write),
        .dmem_address (dmem_address),
        .dmem_wdata   (dmem_wdata),
        .dmem_mbe     (dmem_mbe),
        .dmem_rdata   (dmem_rdata),
        .dmem_resp    (dmem_resp)
`ifdef MEM_MISALIGN_TRAP_EN
        ,
        .misaligned_o (misaligned_o)
`endif
    );

`ifndef MEM_MISALIGN_TRAP_EN
    assign misaligned_o = 1'b0;
`endif

    int total = 0;
    int bad = 0;
    logic chk = 1'b0;

    logic        e_stall, e_done, e_read, e_write, e_mis;
    logic [31:0] e_addr, e_wdata, e_rdata;
    logic [3:0]  e_mbe;

    int          stall_cnt, done_cnt, read_cnt;
    logic [3:0]  last_mbe;
    logic [31:0] last_wdata, last_addr;

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%h want=%h t=%0t", nm, act, exp, $time);
        end
    endtask

    always @(negedge clk) begin
        if (chk) begin
            check("stall", 32'(stall_o), 32'(e_stall));
            check("done", 32'(done_o), 32'(e_done));
            check("dread", 32'(dmem_read), 32'(e_read));
            check("dwrite", 32'(dmem_write), 32'(e_write));
            check("daddr", dmem_address, e_addr);
            check("dwdata", dmem_wdata, e_wdata);
            check("dmbe", 32'(dmem_mbe), 32'(e_mbe));
            check("rdata", rdata_o, e_rdata);
`ifdef MEM_MISALIGN_TRAP_EN
            check("misal", 32'(misaligned_o), 32'(e_mis));
`endif
            if (stall_o) stall_cnt++;
            if (done_o) done_cnt++;
            if (dmem_read) read_cnt++;
            if (dmem_write) begin
                last_mbe   = dmem_mbe;
                last_wdata = dmem_wdata;
                last_addr  = dmem_address;
            end
        end
    end

    function automatic logic [31:0] m_ext(input logic [2:0] f3,
                                          input logic [31:0] a,
                                          input logic [31:0] w);
        logic [31:0] byt, half;
        byt  = (w >> (8 * a[1:0])) & 32'hFF;
        half = (w >> (16 * a[1])) & 32'hFFFF;
        case (f3)
            3'd0: return (byt >= 32'd128) ? (byt | 32'hFFFFFF00) : byt;
            3'd1: return (half >= 32'h8000) ? (half | 32'hFFFF0000) : half;
            3'd4: return byt;
            3'd5: return half;
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] m_mbe(input logic rd, input logic [2:0] f3,
                                         input logic [31:0] a);
        if (rd) return 4'hF;
        case (f3)
            3'd0: return 4'(1 << a[1:0]);
            3'd1: return a[1] ? 4'hC : 4'h3;
            default: return 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                            input logic [31:0] d);
        case (f3)
            3'd0: return (d & 32'hFF) * 32'h01010101;
            3'd1: return (d & 32'hFFFF) * 32'h00010001;
            default: return d;
        endcase
    endfunction

    function automatic logic m_mis(input logic rd, input logic [2:0] f3,
                                   input logic [31:0] a);
`ifdef MEM_MISALIGN_TRAP_EN
        int sz;
        sz = 4;
        if (f3 == 3'd1 || (rd && f3 == 3'd5)) sz = 2;
        else if (f3 != 3'd2) sz = 1;
        return (a % sz) != 0;
`else
        return 1'b0 && rd && (f3 != 0) && (a != 0);
`endif
    endfunction

    task automatic idle_exp();
        e_stall = 1'b0; e_done = 1'b0; e_read = 1'b0; e_write = 1'b0;
        e_addr = 32'h0; e_wdata = 32'h0; e_mbe = 4'h0; e_mis = 1'b0;
    endtask

    task automatic junk_inputs();
        valid_i     = 1'($urandom);
        mem_read_i  = 1'($urandom);
        mem_write_i = 1'($urandom);
        funct3_i    = 3'($urandom);
        addr_i      = $urandom;
        rs2_i       = $urandom;
        dmem_rdata  = $urandom;
    endtask

    task automatic idle();
        @(posedge clk); #1;
        valid_i = 1'($urandom);
        mem_read_i = 1'b0; mem_write_i = 1'b0;
        funct3_i = 3'($urandom); addr_i = $urandom; rs2_i = $urandom;
        dmem_resp = 1'($urandom); dmem_rdata = $urandom;
        idle_exp();
    endtask

    task automatic do_op(input logic v, input logic rd, input logic wr,
                         input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] d, input int lat,
                         input logic [31:0] rword);
        logic isrd, mis;
        @(posedge clk); #1;
        valid_i = v; mem_read_i = rd; mem_write_i = wr;
        funct3_i = f3; addr_i = a; rs2_i = d;
        dmem_resp = 1'($urandom); dmem_rdata = $urandom;
        idle_exp();
        e_stall = v && (rd || wr);
        if (!e_stall) return;
        isrd = rd;
        mis = m_mis(isrd, f3, a);
        if (!mis) begin
            for (int k = 1; k <= lat; k++) begin
                @(posedge clk); #1;
                junk_inputs();
                dmem_resp = (k == lat);
                if (k == lat) dmem_rdata = rword;
                e_stall = 1'b1; e_done = 1'b0;
                e_read = isrd; e_write = !isrd;
                e_addr = {a[31:2], 2'b00};
                e_mbe = m_mbe(isrd, f3, a);
                e_wdata = isrd ? 32'h0 : m_wdata(f3, d);
            end
        end
        @(posedge clk); #1;
        junk_inputs();
        dmem_resp = 1'($urandom);
        idle_exp();
        e_done = 1'b1;
        e_mis = mis;
        if (isrd && !mis) e_rdata = m_ext(f3, a, rword);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        funct3_i = 3'h0; addr_i = 32'h0; rs2_i = 32'h0;
        dmem_rdata = 32'h0; dmem_resp = 1'b0;
        idle_exp();
        e_rdata = 32'h0;
        stall_cnt = 0; done_cnt = 0; read_cnt = 0;
        last_mbe = 4'h0; last_wdata = 32'h0; last_addr = 32'h0;
        @(posedge clk); #1;
        chk = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;

        stall_cnt = 0; done_cnt = 0;
        do_op(1'b1, 1'b0, 1'b1, 3'd0, 32'h1003, 32'h000000AB, 3, 32'h0);
        idle();
        @(negedge clk);
        check("sb_mbe", 32'(last_mbe), 32'h8);
        check("sb_wdata", last_wdata, 32'hABABABAB);
        check("sb_addr", last_addr, 32'h1000);
        check("sb_stalls", stall_cnt, 4);
        check("sb_dones", done_cnt, 1);

        do_op(1'b1, 1'b1, 1'b0, 3'd0, 32'h2001, 32'h0, 1, 32'h000080FF);
        idle();
        @(negedge clk);
        check("lb_lit", rdata_o, 32'hFFFFFF80);
        do_op(1'b1, 1'b1, 1'b0, 3'd4, 32'h2001, 32'h0, 2, 32'h000080FF);
        idle();
        @(negedge clk);
        check("lbu_lit", rdata_o, 32'h00000080);
        do_op(1'b1, 1'b1, 1'b0, 3'd1, 32'h2002, 32'h0, 1, 32'h80010000);
        idle();
        @(negedge clk);
        check("lh_lit", rdata_o, 32'hFFFF8001);
        do_op(1'b1, 1'b1, 1'b1, 3'd5, 32'h2002, 32'h0, 4, 32'h80010000);
        idle();
        @(negedge clk);
        check("lhu_lit", rdata_o, 32'h00008001);

        do_op(1'b1, 1'b0, 1'b0, 3'd2, 32'h5000, 32'h1234, 1, 32'h0);
        @(negedge clk);
        check("alu_nostall", 32'(stall_o), 32'h0);
        idle();
        @(negedge clk);
        check("alu_keep", rdata_o, 32'h00008001);

        done_cnt = 0;
        @(posedge clk); #1;
        valid_i = 1'b1; mem_read_i = 1'b1; mem_write_i = 1'b0;
        funct3_i = 3'd2; addr_i = 32'h4000; dmem_resp = 1'b0;
        idle_exp();
        e_stall = 1'b1;
        @(posedge clk); #1;
        valid_i = 1'b0; rst = 1'b1; dmem_resp = 1'b1;
        dmem_rdata = 32'hDEADBEEF;
        e_read = 1'b1; e_addr = 32'h4000; e_mbe = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0; dmem_resp = 1'b0;
        idle_exp();
        e_rdata = 32'h0;
        idle();
        @(negedge clk);
        check("rst_nodone", done_cnt, 0);
        do_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h4004, 32'h0, 2, 32'hCAFEF00D);
        idle();
        @(negedge clk);
        check("lw_lit", rdata_o, 32'hCAFEF00D);

`ifdef MEM_MISALIGN_TRAP_EN
        read_cnt = 0; done_cnt = 0;
        do_op(1'b1, 1'b1, 1'b0, 3'd2, 32'h3002, 32'h0, 1, 32'h0);
        @(negedge clk);
        check("mis_lit", 32'(misaligned_o && done_o), 32'h1);
        idle();
        @(negedge clk);
        check("mis_noread", read_cnt, 0);
        check("mis_done", done_cnt, 1);
`endif

        for (int i = 0; i < 400; i++) begin
            logic v, rd, wr;
            v  = ($urandom_range(9) != 0);
            rd = 1'($urandom);
            wr = 1'($urandom);
            do_op(v, rd, wr, 3'($urandom), $urandom, $urandom,
                  $urandom_range(4, 1), $urandom);
            if ($urandom_range(3) == 0) idle();
        end
        idle();
        @(negedge clk);
        chk = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
